// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic         flush;
    logic [2:0]   funct3;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [4:0]   rd_add;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [4:0]   wb_add;

    modport master (
        output start, flush, funct3, rs1_data, rs2_data, rd_add,
        input  busy, done, result, wb_add
    );

    modport slave (
        input  start, flush, funct3, rs1_data, rs2_data, rd_add,
        output busy, done, result, wb_add
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with a final sign-correction step.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] ITER_ONE  = IW'(1);
    localparam logic [IW-1:0] ITER_LAST = IW'(N - 1);
    localparam logic [N-1:0]  ONES      = {N{1'b1}};
    localparam logic [N-1:0]  ZERO      = {N{1'b0}};
    localparam logic [N-1:0]  MOST_NEG  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_r;
    logic [IW-1:0]  iter_r;
    logic [2*N:0]   acc_r;
    logic [N-1:0]   b_r;
    logic [2:0]     funct3_r;
    logic           neg_res_r;
    logic           neg_rem_r;
    logic [4:0]     rd_r;
    logic           busy_r;
    logic           done_r;
    logic [N-1:0]   result_r;
    logic [4:0]     wb_add_r;

    logic           is_div_s;
    logic           a_signed_s;
    logic           b_signed_s;
    logic           a_neg_s;
    logic           b_neg_s;
    logic [N-1:0]   a_mag_s;
    logic [N-1:0]   b_mag_s;
    logic           div_zero_s;
    logic           overflow_s;
    logic           special_s;
    logic [N-1:0]   special_val_s;

    // Operand decode at accept: signedness, magnitudes and the results that need no iteration.
    always_comb begin
        is_div_s = bus.funct3[2];
        if (is_div_s) begin
            a_signed_s = ~bus.funct3[0];
            b_signed_s = ~bus.funct3[0];
        end else begin
            a_signed_s = (bus.funct3 != 3'b011);
            b_signed_s = ~bus.funct3[1];
        end
        a_neg_s    = a_signed_s & bus.rs1_data[N-1];
        b_neg_s    = b_signed_s & bus.rs2_data[N-1];
        a_mag_s    = a_neg_s ? -bus.rs1_data : bus.rs1_data;
        b_mag_s    = b_neg_s ? -bus.rs2_data : bus.rs2_data;
        div_zero_s = (bus.rs2_data == ZERO);
        overflow_s = ~bus.funct3[0] & (bus.rs1_data == MOST_NEG) & (bus.rs2_data == ONES);
        special_s  = is_div_s & (div_zero_s | overflow_s);
        if (div_zero_s) begin
            special_val_s = bus.funct3[1] ? bus.rs1_data : ONES;
        end else begin
            special_val_s = bus.funct3[1] ? ZERO : MOST_NEG;
        end
    end

    logic [N:0]     sum_s;
    logic [N:0]     diff_s;
    logic [2*N:0]   step_s;

    // One iteration: acc_r holds {partial/remainder, multiplier/quotient} for both operations.
    always_comb begin
        sum_s  = acc_r[2*N:N] + {1'b0, b_r};
        diff_s = acc_r[2*N-1:N-1] - {1'b0, b_r};
        if (funct3_r[2]) begin
            if (!diff_s[N]) begin
                step_s = {diff_s, acc_r[N-2:0], 1'b1};
            end else begin
                step_s = {acc_r[2*N-1:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            step_s = {1'b0, sum_s, acc_r[N-1:1]};
        end else begin
            step_s = {1'b0, acc_r[2*N:1]};
        end
    end

    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quot_s;
    logic [N-1:0]   rem_s;
    logic [N-1:0]   fix_val_s;

    // Sign correction and result selection applied in FIX.
    always_comb begin
        prod_s = neg_res_r ? -acc_r[2*N-1:0] : acc_r[2*N-1:0];
        quot_s = neg_res_r ? -acc_r[N-1:0]   : acc_r[N-1:0];
        rem_s  = neg_rem_r ? -acc_r[2*N-1:N] : acc_r[2*N-1:N];
        case (funct3_r)
            3'b000:                 fix_val_s = prod_s[N-1:0];
            3'b001, 3'b010, 3'b011: fix_val_s = prod_s[2*N-1:N];
            3'b100, 3'b101:         fix_val_s = quot_s;
            3'b110, 3'b111:         fix_val_s = rem_s;
            default:                fix_val_s = ZERO;
        endcase
    end

    // Control FSM with registered busy/done/result/wb_add.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            iter_r    <= {IW{1'b0}};
            acc_r     <= {(2*N+1){1'b0}};
            b_r       <= ZERO;
            funct3_r  <= 3'b000;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            rd_r      <= 5'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= ZERO;
            wb_add_r  <= 5'd0;
        end else if (bus.flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        funct3_r  <= bus.funct3;
                        rd_r      <= bus.rd_add;
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= is_div_s & a_neg_s;
                        acc_r     <= {{(N+1){1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
                        b_r       <= is_div_s ? b_mag_s : a_mag_s;
                        iter_r    <= {IW{1'b0}};
                        if (special_s) begin
                            result_r <= special_val_s;
                            wb_add_r <= bus.rd_add;
                            done_r   <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r  <= step_s;
                    iter_r <= iter_r + ITER_ONE;
                    if (iter_r == ITER_LAST) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    result_r <= fix_val_s;
                    wb_add_r <= rd_r;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.wb_add = wb_add_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, randomized ops against an
// arithmetic reference model, flush, ignored starts and reset mid-operation.
module tb_muldiv_unit;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MNEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.N(32)) mif ();
    muldiv_unit #(.N(32)) dut (.clk(clk), .reset(reset), .bus(mif));

    // RISC-V M semantics via 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sq;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return ONES;
                if (a == MNEG && b == ONES) return MNEG;
                sq = sa / sb; return sq[31:0];
            end
            3'b101: begin
                if (b == 32'd0) return ONES;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == MNEG && b == ONES) return 32'd0;
                sq = sa % sb; return sq[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 32'd0 || (!f3[0] && a == MNEG && b == ONES));
    endfunction

    // Issues one op, scrambles the operand ports afterwards, and reports what the unit returned.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output logic [4:0] wb,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        mif.start = 1'b1; mif.funct3 = f3; mif.rs1_data = a; mif.rs2_data = b; mif.rd_add = rd;
        lat = 0; busy_cnt = 0; res = 32'hDEAD_BEEF; wb = 5'd0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mif.start = 1'b0;
                mif.funct3 = 3'($urandom); mif.rs1_data = $urandom; mif.rs2_data = $urandom;
                mif.rd_add = 5'($urandom);
            end
            if (mif.busy) busy_cnt++;
            if (mif.done) begin lat = c; res = mif.result; wb = mif.wb_add; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mif.busy, mif.done, mif.result, mif.wb_add} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b result=%h wb=%0d required all 0",
                     mif.busy, mif.done, mif.result, mif.wb_add);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  f3 [12] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110,
                                 3'b101, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] ta [12] = '{32'd7, MNEG, ONES, ONES, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'd100, 32'd100, 32'h1234, 32'h1234, MNEG, MNEG};
        logic [31:0] tb [12] = '{32'hFFFF_FFF9, MNEG, ONES, ONES, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, ONES, ONES};
        logic [31:0] te [12] = '{32'hFFFF_FFCF, 32'h4000_0000, 32'hFFFF_FFFE, ONES, 32'hFFFF_FFFD,
                                 ONES, 32'd14, 32'd2, ONES, 32'h1234, MNEG, 32'd0};
        int          tl [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
        logic [31:0] res; logic [4:0] wb; int lat, bc;
        for (int i = 0; i < 12; i++) begin
            run_op(f3[i], ta[i], tb[i], 5'(i + 5), res, wb, lat, bc);
            checks++;
            if (res !== te[i] || wb !== 5'(i + 5)) begin
                errors++;
                $display("FAIL directed_%0d result=%h wb=%0d required result=%h wb=%0d", i, res, wb, te[i], i + 5);
            end
            checks++;
            if (lat != tl[i] || bc != (tl[i] == 34 ? 33 : 0)) begin
                errors++;
                $display("FAIL directed_timing_%0d done_cycle=%0d busy_cycles=%0d required %0d/%0d",
                         i, lat, bc, tl[i], tl[i] == 34 ? 33 : 0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp; logic [2:0] f3; logic [4:0] rd, wb; int lat, bc, el;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = MNEG; b = ONES; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            rd  = 5'($urandom);
            exp = ref_op(f3, a, b);
            el  = is_special(f3, a, b) ? 1 : 34;
            run_op(f3, a, b, rd, res, wb, lat, bc);
            checks++;
            if (res !== exp || wb !== rd || lat != el) begin
                errors++;
                $display("FAIL random_%0d f3=%0d a=%h b=%h result=%h wb=%0d cyc=%0d required %h/%0d/%0d",
                         i, f3, a, b, res, wb, lat, exp, rd, el);
            end
            @(negedge clk);
            checks++;
            if (mif.done !== 1'b0 || mif.result !== exp || mif.wb_add !== rd) begin
                errors++;
                $display("FAIL random_hold_%0d done=%b result=%h wb=%0d required 0/%h/%0d",
                         i, mif.done, mif.result, mif.wb_add, exp, rd);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] res; logic [4:0] wb; int lat, bc, seen_done;
        run_op(3'b000, 32'd6, 32'd7, 5'd17, res, wb, lat, bc);
        @(negedge clk);
        mif.start = 1'b1; mif.funct3 = 3'b100; mif.rs1_data = 32'd1000; mif.rs2_data = 32'd3; mif.rd_add = 5'd2;
        seen_done = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (mif.done) seen_done++;
            if (c == 1) mif.start = 1'b0;
            if (c == 10) mif.flush = 1'b1;
        end
        mif.flush = 1'b0;
        checks++;
        if (mif.busy !== 1'b0 || seen_done != 0 || mif.result !== 32'd42 || mif.wb_add !== 5'd17) begin
            errors++;
            $display("FAIL flush_abort busy=%b dones=%0d result=%h wb=%0d required 0/0/0000002a/17",
                     mif.busy, seen_done, mif.result, mif.wb_add);
        end
        mif.start = 1'b1; mif.funct3 = 3'b000; mif.rs1_data = 32'd3; mif.rs2_data = 32'd4; mif.rd_add = 5'd9;
        lat = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) mif.start = 1'b0;
            if (mif.done) begin lat = c; res = mif.result; end
        end
        checks++;
        if (lat != 34 || res !== 32'd12 || mif.wb_add !== 5'd9) begin
            errors++;
            $display("FAIL flush_restart cyc=%0d result=%h wb=%0d required 34/0000000c/9", lat, res, mif.wb_add);
        end
        // flush together with start while idle: the start must be dropped
        @(negedge clk);
        mif.start = 1'b1; mif.flush = 1'b1; mif.funct3 = 3'b001;
        @(negedge clk);
        mif.start = 1'b0; mif.flush = 1'b0;
        seen_done = 0; bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (mif.done) seen_done++;
            if (mif.busy) bc++;
        end
        checks++;
        if (seen_done != 0 || bc != 0) begin
            errors++;
            $display("FAIL flush_with_start dones=%0d busy_cycles=%0d required 0/0", seen_done, bc);
        end
        // flush during the DONE cycle: the pulse is already out
        mif.start = 1'b1; mif.funct3 = 3'b101; mif.rs1_data = 32'h55; mif.rs2_data = 32'd0; mif.rd_add = 5'd4;
        @(negedge clk);
        mif.start = 1'b0;
        checks++;
        if (mif.done !== 1'b1 || mif.result !== ONES) begin
            errors++;
            $display("FAIL flush_in_done done=%b result=%h required 1/ffffffff", mif.done, mif.result);
        end
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        checks++;
        if (mif.done !== 1'b0 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_after_done done=%b busy=%b required 0/0", mif.done, mif.busy);
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] a, b, res; int lat, bc, seen_done;
        a = 32'h0012_3456; b = 32'hFFFF_F777;
        @(negedge clk);
        mif.start = 1'b1; mif.funct3 = 3'b000; mif.rs1_data = a; mif.rs2_data = b; mif.rd_add = 5'd3;
        lat = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1 || c == 6 || c == 21) mif.start = 1'b0;
            if (c == 5 || c == 20) begin
                mif.start = 1'b1; mif.funct3 = 3'b101; mif.rs1_data = 32'd99; mif.rs2_data = 32'd0; mif.rd_add = 5'd30;
            end
            if (mif.done) begin lat = c; res = mif.result; end
        end
        checks++;
        if (lat != 34 || res !== ref_op(3'b000, a, b) || mif.wb_add !== 5'd3) begin
            errors++;
            $display("FAIL ignore_start cyc=%0d result=%h wb=%0d required 34/%h/3", lat, res, mif.wb_add, ref_op(3'b000, a, b));
        end
        // start presented in the DONE cycle is dropped
        mif.start = 1'b1; mif.funct3 = 3'b011;
        @(negedge clk);
        mif.start = 1'b0;
        bc = 0;
        repeat (5) begin @(negedge clk); if (mif.busy) bc++; end
        checks++;
        if (bc != 0) begin
            errors++;
            $display("FAIL start_in_done busy_cycles=%0d required 0", bc);
        end
        // reset mid-operation
        mif.start = 1'b1; mif.funct3 = 3'b011; mif.rs1_data = 32'd5; mif.rs2_data = 32'd5; mif.rd_add = 5'd8;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) mif.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({mif.busy, mif.done, mif.result, mif.wb_add} !== 39'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b result=%h wb=%0d required all 0",
                     mif.busy, mif.done, mif.result, mif.wb_add);
        end
        seen_done = 0;
        repeat (40) begin @(negedge clk); if (mif.done) seen_done++; end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done dones=%0d required 0", seen_done);
        end
    endtask

    initial begin
        mif.start = 1'b0; mif.flush = 1'b0; mif.funct3 = 3'b000;
        mif.rs1_data = 32'd0; mif.rs2_data = 32'd0; mif.rd_add = 5'd0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_ignore_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
